// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arbState_e;

  localparam int DefAddrW        = 32;
  localparam int DefDataW        = 32;
  localparam int DefMaxDataBurst = 4;

endpackage

// File: rtl/mem_arb_perf_counters.sv
// Free-running, wrapping event counters for the arbiter.
// Built only when ARB_PERF_CNT_EN is defined.
module mem_arb_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetchGrant,
  input  logic        dataGrant,
  input  logic        fetchWait,
  output logic [31:0] fetchGrants,
  output logic [31:0] dataGrants,
  output logic [31:0] fetchWaitCycles
);

  // Count grants and fetch wait cycles; all three wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchGrants     <= '0;
      dataGrants      <= '0;
      fetchWaitCycles <= '0;
    end else begin
      if (fetchGrant) fetchGrants     <= fetchGrants + 32'd1;
      if (dataGrant)  dataGrants      <= dataGrants + 32'd1;
      if (fetchWait)  fetchWaitCycles <= fetchWaitCycles + 32'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins ties unless a fetch has waited through MAX_DATA_BURST data
// grants. Define ARB_PERF_CNT_EN to add the perf_* counter outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DefAddrW,
  parameter int DATA_W         = DefDataW,
  parameter int MAX_DATA_BURST = DefMaxDataBurst
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_grants,
  output logic [31:0]       perf_data_grants,
  output logic [31:0]       perf_fetch_wait
`endif
);

  localparam int CntW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_DATA_BURST);

  arbState_e         state;
  logic [CntW-1:0]   burstCnt;
  logic [ADDR_W-1:0] capAddr;
  logic              capWe;
  logic [DATA_W-1:0] capWdata;
  logic [DATA_W-1:0] ifRdataQ;
  logic [DATA_W-1:0] dRdataQ;
  logic              fetchStarved;
  logic              grantData;
  logic              grantFetch;
  logic              loadDone;

  function automatic logic [CntW-1:0] satInc(input logic [CntW-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

  // Grant decisions are only made in IDLE; a starved fetch overrides data
  always_comb begin
    fetchStarved = if_req && (burstCnt == CntMax);
    grantData    = (state == IDLE) && d_req && !fetchStarved;
    grantFetch   = (state == IDLE) && !grantData && if_req;
  end

  // Ready pulses track the owner's ack; reset suppresses a completing ack
  always_comb begin
    if_ready  = (state == FETCH) && mem_ack && !rst;
    d_ready   = (state == DATA) && mem_ack && !rst;
    loadDone  = d_ready && !capWe;
    if_rdata  = if_ready ? mem_rdata : ifRdataQ;
    d_rdata   = loadDone ? mem_rdata : dRdataQ;
    mem_req   = (state != IDLE);
    busy      = (state != IDLE);
    mem_we    = (state == DATA) && capWe;
    mem_addr  = capAddr;
    mem_wdata = capWdata;
  end

  // FSM and request capture; the captured copy drives memory until ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      capAddr  <= '0;
      capWe    <= 1'b0;
      capWdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grantData) begin
            state    <= DATA;
            capAddr  <= d_addr;
            capWe    <= d_we;
            capWdata <= d_wdata;
          end else if (grantFetch) begin
            state    <= FETCH;
            capAddr  <= if_addr;
            capWe    <= 1'b0;
            capWdata <= '0;
          end
        end
        FETCH, DATA: begin
          if (mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count data grants that bypass a waiting fetch; clear once fetch is served or gone
  always_ff @(posedge clk) begin
    if (rst) begin
      burstCnt <= '0;
    end else if (grantFetch || ((state == IDLE) && !if_req)) begin
      burstCnt <= '0;
    end else if (grantData && if_req) begin
      burstCnt <= satInc(burstCnt);
    end
  end

  // Hold the last read data per requester; stores leave the load data alone
  always_ff @(posedge clk) begin
    if (rst) begin
      ifRdataQ <= '0;
      dRdataQ  <= '0;
    end else begin
      if (if_ready) ifRdataQ <= mem_rdata;
      if (loadDone) dRdataQ  <= mem_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  mem_arb_perf_counters uPerf (
    .clk             (clk),
    .rst             (rst),
    .fetchGrant      (grantFetch),
    .dataGrant       (grantData),
    .fetchWait       (if_req && !if_ready),
    .fetchGrants     (perf_fetch_grants),
    .dataGrants      (perf_data_grants),
    .fetchWaitCycles (perf_fetch_wait)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized requester/memory traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_fetch_grants;
  logic [31:0]   perf_data_grants;
  logic [31:0]   perf_fetch_wait;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_BURST(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_fetch_grants (perf_fetch_grants),
    .perf_data_grants  (perf_data_grants),
    .perf_fetch_wait   (perf_fetch_wait)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the memory, what was latched for it, and how
  // many data accesses have jumped ahead of a waiting fetch.
  int            owner;        // 0 = nobody, 1 = fetch, 2 = data
  int            dataStreak;
  logic [AW-1:0] mAddr;
  logic          mWe;
  logic [DW-1:0] mWdata;
  logic [DW-1:0] mIfRd;
  logic [DW-1:0] mDRd;
  int unsigned   pFetch, pData, pWait;
  logic          lastIfReady = 1'b0;
  logic          lastDReady = 1'b0;

  logic          obsIfReady, obsDReady, obsMemReq, obsMemWe, obsBusy;
  logic [AW-1:0] obsMemAddr;
  logic [DW-1:0] obsMemWdata, obsIfRdata, obsDRdata;

  // Memory responder state
  int            memLat = 1;
  logic [DW-1:0] memData = '0;
  bit            spurious = 1'b0;
  bit            inAccess = 1'b0;
  int            memWait = 0;

  task automatic modelReset();
    owner = 0; dataStreak = 0;
    mAddr = '0; mWe = 1'b0; mWdata = '0; mIfRd = '0; mDRd = '0;
    pFetch = 0; pData = 0; pWait = 0;
  endtask

  task automatic evalCycle();
    logic          eIf, eD;
    logic [DW-1:0] eIfRd, eDRd;
    eIf   = (owner == 1) && mem_ack && !rst;
    eD    = (owner == 2) && mem_ack && !rst;
    eIfRd = eIf ? mem_rdata : mIfRd;
    eDRd  = (eD && !mWe) ? mem_rdata : mDRd;
    checkVal("busy",      busy,      owner != 0);
    checkVal("mem_req",   mem_req,   owner != 0);
    checkVal("mem_we",    mem_we,    (owner == 2) && mWe);
    checkVal("mem_addr",  mem_addr,  mAddr);
    checkVal("mem_wdata", mem_wdata, mWdata);
    checkVal("if_ready",  if_ready,  eIf);
    checkVal("d_ready",   d_ready,   eD);
    checkVal("if_rdata",  if_rdata,  eIfRd);
    checkVal("d_rdata",   d_rdata,   eDRd);
`ifdef ARB_PERF_CNT_EN
    checkVal("perf_fetch_grants", perf_fetch_grants, pFetch);
    checkVal("perf_data_grants",  perf_data_grants,  pData);
    checkVal("perf_fetch_wait",   perf_fetch_wait,   pWait);
`endif
    obsIfReady = if_ready; obsDReady = d_ready; obsMemReq = mem_req;
    obsMemWe = mem_we; obsBusy = busy; obsMemAddr = mem_addr;
    obsMemWdata = mem_wdata; obsIfRdata = if_rdata; obsDRdata = d_rdata;
    if (rst) begin
      modelReset();
    end else begin
      if (if_req && !eIf) pWait++;
      if (owner == 0) begin
        if (d_req && !(if_req && dataStreak == MAXB)) begin
          owner = 2; mAddr = d_addr; mWe = d_we; mWdata = d_wdata; pData++;
          if (if_req && dataStreak < MAXB) dataStreak++;
        end else if (if_req) begin
          owner = 1; mAddr = if_addr; mWe = 1'b0; mWdata = '0; pFetch++;
          dataStreak = 0;
        end
        if (!if_req) dataStreak = 0;
      end else if (mem_ack) begin
        if (owner == 1) mIfRd = mem_rdata;
        else if (!mWe) mDRd = mem_rdata;
        owner = 0;
      end
    end
    lastIfReady = eIf;
    lastDReady  = eD;
  endtask

  task automatic step();
    @(negedge clk);
    evalCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveMem();
    if (owner != 0) begin
      if (!inAccess) begin
        inAccess = 1'b1;
        memWait  = memLat - 1;
      end
      if (memWait == 0) begin
        mem_ack = 1'b1; mem_rdata = memData; inAccess = 1'b0;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom; memWait--;
      end
    end else begin
      inAccess  = 1'b0;
      mem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic randDrive();
    if (if_req) begin
      if (lastIfReady) begin
        if ($urandom_range(0, 1) == 0) if_req = 1'b0;
        else if_addr = $urandom;
      end else if (owner == 1) begin
        if_addr = $urandom;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      if_req = 1'b1; if_addr = $urandom;
    end
    if (d_req) begin
      if (lastDReady) begin
        if ($urandom_range(0, 1) == 0) d_req = 1'b0;
        else begin d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1)); end
      end else if (owner == 2) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
      end
    end else if ($urandom_range(0, 2) == 0) begin
      d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int pulses, dCyc, fCyc, dCount, k;
    int streaks[2];
    logic [DW-1:0] got;
    modelReset();
    @(posedge clk);
    #1;

    // Reset state, then reset while a load waits for its ack
    step();
    rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; memLat = 8;
    driveMem(); step();
    driveMem(); step();
    checkVal("rst_pre_busy", obsBusy, 1'b1);
    rst = 1'b1;
    driveMem(); mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    checkVal("rst_no_dready", obsDReady, 1'b0);
    rst = 1'b0; d_req = 1'b0;
    driveMem(); step();
    checkVal("rst_mem_req",  obsMemReq,  1'b0);
    checkVal("rst_busy",     obsBusy,    1'b0);
    checkVal("rst_d_ready",  obsDReady,  1'b0);
    checkVal("rst_mem_addr", obsMemAddr, 32'h0);
    checkVal("rst_d_rdata",  obsDRdata,  32'h0);

    // Single fetch
    if_req = 1'b1; if_addr = 32'h100; memLat = 2; memData = 32'hE3A01005;
    pulses = 0; got = '0;
    for (int i = 0; i < 12; i++) begin
      if (lastIfReady) if_req = 1'b0;
      driveMem(); step();
      if (obsMemReq) begin
        checkVal("fetch_addr", obsMemAddr, 32'h100);
        checkVal("fetch_we",   obsMemWe,   1'b0);
      end
      if (obsIfReady) begin pulses++; got = obsIfRdata; end
    end
    checkVal("fetch_pulses", pulses, 1);
    checkVal("fetch_rdata", got, 32'hE3A01005);
    checkVal("fetch_rdata_hold", obsIfRdata, 32'hE3A01005);
    checkVal("fetch_idle", obsBusy, 1'b0);

    // Store: wdata/addr must hold even if the requester wiggles its inputs
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    memLat = 3; memData = 32'h55AA55AA; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (lastDReady) d_req = 1'b0;
      else if (owner == 2) begin d_addr = $urandom; d_wdata = $urandom; d_we = 1'b0; end
      driveMem(); step();
      if (obsMemReq) begin
        checkVal("store_we",    obsMemWe,    1'b1);
        checkVal("store_addr",  obsMemAddr,  32'h200);
        checkVal("store_wdata", obsMemWdata, 32'hDEADBEEF);
      end
      if (obsDReady) pulses++;
    end
    checkVal("store_pulses", pulses, 1);
    checkVal("store_d_rdata", obsDRdata, 32'h0);

    // Simultaneous requests with an empty burst count
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    memLat = 1; memData = 32'hA5A5F00D; dCyc = -1; fCyc = -1; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (lastDReady) d_req = 1'b0;
      if (lastIfReady) if_req = 1'b0;
      driveMem(); step();
      if (obsMemReq && pulses == 0) begin
        checkVal("simul_first_addr", obsMemAddr, 32'h500);
        pulses = 1;
      end
      if (obsDReady && dCyc < 0) dCyc = i;
      if (obsIfReady && fCyc < 0) fCyc = i;
    end
    checkVal("simul_data_cycle", dCyc, 1);
    checkVal("simul_fetch_gap", fCyc - dCyc, 2);

    // Starvation bound: fetch waits through exactly MAXB data grants
    if_req = 1'b1; if_addr = 32'h600;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; memLat = 1;
    dCount = 0; k = 0; streaks[0] = -1; streaks[1] = -1;
    for (int i = 0; i < 80 && k < 2; i++) begin
      if (lastDReady) d_addr = $urandom;
      if (lastIfReady) if_addr = $urandom;
      memData = $urandom;
      driveMem(); step();
      if (obsDReady) dCount++;
      if (obsIfReady) begin streaks[k] = dCount; dCount = 0; k++; end
    end
    checkVal("burst_fetches", k, 2);
    checkVal("burst_first",  streaks[0], MAXB);
    checkVal("burst_second", streaks[1], MAXB);
    if_req = 1'b0; d_req = 1'b0;
    driveMem(); step();

`ifdef ARB_PERF_CNT_EN
    // Perf counters: 3 fetches and 2 loads on a 1-cycle memory
    rst = 1'b1; driveMem(); step(); rst = 1'b0;
    memLat = 1;
    for (int op = 0; op < 5; op++) begin
      memData = $urandom;
      if (op % 2 == 0) begin if_req = 1'b1; if_addr = $urandom; end
      else begin d_req = 1'b1; d_we = 1'b0; d_addr = $urandom; end
      for (int i = 0; i < 10; i++) begin
        driveMem(); step();
        if (lastIfReady || lastDReady) break;
      end
      if_req = 1'b0; d_req = 1'b0;
    end
    driveMem(); step();
    checkVal("perf_fetch_total", perf_fetch_grants, 32'd3);
    checkVal("perf_data_total",  perf_data_grants,  32'd2);
    checkVal("perf_wait_total",  perf_fetch_wait,   pWait);
`endif

    // Randomized traffic with random latency, stray acks and occasional reset
    spurious = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      memLat  = $urandom_range(1, 3);
      memData = $urandom;
      rst     = ($urandom_range(0, 299) == 0);
      randDrive();
      driveMem();
      step();
    end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; spurious = 1'b0;
    driveMem(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined core.
- Data accesses have priority over fetches.
- A burst limit bounds fetch starvation.
- Requesters see a req/ready handshake. Stall and hazard logic use `if_ready`/`d_ready` to hold the stages.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_BURST, 4, max consecutive data grants while a fetch is pending (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data
- if_ready  out  1  fetch complete (single-cycle)
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_ready  out  1  data access complete (single-cycle)
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion; latency 1..N cycles after mem_req rises
- busy  out  1  high while state != IDLE

Behaviour:
- Reset state: all outputs 0, state=IDLE, burst counter=0, rdata registers=0.
- FSM states: IDLE, FETCH, DATA.
- IDLE:
  - If d_req && !(if_req && cnt==MAX_DATA_BURST): go to DATA.
  - Else if if_req: go to FETCH.
  - Else stay in IDLE.
  - On a grant, capture addr, we and wdata into registers.
- FETCH/DATA:
  - mem_req=1; mem_addr/mem_we/mem_wdata come from the captured registers and are stable until ack.
  - mem_we=0 in FETCH.
  - On mem_ack, return to IDLE. The minimum turnaround is one IDLE cycle between accesses.
- Ready and read data:
  - if_ready = (state==FETCH) && mem_ack; d_ready = (state==DATA) && mem_ack. Both are combinational.
  - if_rdata/d_rdata = mem_rdata during the owner's ready cycle. Otherwise they hold the last registered value.
  - Stores do not update d_rdata.
- Requester rule: drop req, or present a new request, on the edge after ready. A req still high in the following IDLE cycle is treated as a new access.
- Burst counter (cnt):
  - Increments on each DATA grant made while if_req=1, saturating at MAX_DATA_BURST.
  - Cleared on a FETCH grant, or in any IDLE cycle with if_req=0.
- Simultaneous requests in IDLE: data wins unless cnt==MAX_DATA_BURST, in which case fetch wins.
- mem_ack in IDLE is ignored.
- Request inputs changing mid-access are ignored; the captured registers are used.
- rst mid-access: return to IDLE next edge, mem_req=0, no ready pulse issued.
- Fetch-only traffic with a 1-cycle memory gives one fetch every 2 cycles.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetch_grants[31:0], perf_data_grants[31:0] and perf_fetch_wait[31:0].
  - perf_fetch_wait counts cycles with if_req=1 && !if_ready.
  - All counters wrap, and are cleared by rst.
- When undefined: these ports and their logic are absent; arbitration is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE=2'd0, FETCH=2'd1, DATA=2'd2)
  - default width constants
- Sub-module mem_arb_perf_counters holds the three counters and is instantiated only under ARB_PERF_CNT_EN.

Test Plan:
- Reset:
  - Stimulus: assert rst during a DATA access awaiting ack.
  - Required: next cycle mem_req=0, busy=0, no d_ready, all outputs 0.
- Single fetch:
  - Stimulus: if_req, if_addr=0x100; memory acks 2 cycles after mem_req with rdata=0xE3A01005.
  - Required: mem_addr=0x100, mem_we=0, one if_ready pulse with if_rdata=0xE3A01005, then IDLE.
- Store:
  - Stimulus: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF.
  - Required: mem_we=1 with address and data stable until ack, d_ready pulse, d_rdata unchanged.
- Simultaneous requests:
  - Stimulus: if_req and d_req rise together, cnt=0.
  - Required: DATA served first, then FETCH after the data ack plus one IDLE cycle.
- Starvation bound:
  - Stimulus: if_req held; d_req re-asserted continuously; MAX_DATA_BURST=4.
  - Required: exactly 4 data grants, then a fetch grant, then cnt=0.
- Perf counters (ARB_PERF_CNT_EN):
  - Stimulus: 3 fetches and 2 loads, 1-cycle memory.
  - Required: perf_fetch_grants=3, perf_data_grants=2, perf_fetch_wait equal to the bench-counted wait cycles.
